dekatron_counter: RTL

- Parametrised successor to the single-ring dekatron model: an N-digit glow-transfer counter tube with three cathodes per digit (main, guide1, guide2).
- Counting is a handshaked, multi-cycle, two-phase guide-pulse sequence. The glow passes through the guide cathodes, as in a real tube.
- Adds load, carry/borrow on wrap, and resync from sensed cathodes with error flagging.
- Used as the digit element in the DekatronPC's register and counter chains. The carry/borrow outputs feed the next decade.

---
 rtl/dekatron_counter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dekatron_counter.sv
// dekatron_counter: one decade of a glow-transfer counter tube.
//
// The glow sits on one of DIGITS main cathodes. A step moves it through the
// two guide cathodes between adjacent mains. Each guide phase is held for
// PULSE_CYCLES clocks, exactly as the P1/P2 drive pulses of a real tube.
// The block also supports a direct load, and a resync from the sensed
// cathode pattern. Carry and borrow pulses feed the next decade.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   inc, dec           step forward / backward request (sampled in IDLE)
//   load, load_digit   direct set request and its value (sampled in IDLE)
//   sense, sense_en    sensed glow pattern and resync request (in IDLE)
//   cathodes           one-hot glow position, 3 lines per digit:
//                      main K, guide1 after K, guide2 after K
//   guide1, guide2     P1 / P2 drive, high during their phase
//   digit              current main-cathode index
//   busy               high whenever the sequencer is not idle
//   done               one-cycle pulse when an operation completes
//   carry, borrow      one-cycle pulses with done on a forward/backward wrap
//   sync_err           one-cycle pulse when a load or sense is rejected
module dekatron_counter #(
  parameter int DIGITS       = 10,
  parameter int CATHODES     = 3 * DIGITS,
  parameter int PULSE_CYCLES = 2,
  parameter int DW           = $clog2(DIGITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  input  logic                load,
  input  logic [DW-1:0]       load_digit,
  input  logic [CATHODES-1:0] sense,
  input  logic                sense_en,
  output logic [CATHODES-1:0] cathodes,
  output logic                guide1,
  output logic                guide2,
  output logic [DW-1:0]       digit,
  output logic                busy,
  output logic                done,
  output logic                carry,
  output logic                borrow,
  output logic                sync_err
);

  if (DIGITS < 2) begin : g_bad_digits
    $error("dekatron_counter: DIGITS must be at least 2");
  end
  if (CATHODES != 3 * DIGITS) begin : g_bad_cathodes
    $error("dekatron_counter: CATHODES must equal 3*DIGITS");
  end
  if (PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("dekatron_counter: PULSE_CYCLES must be at least 1");
  end

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PH1, PH2, FIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                down_q, down_d;   // direction of the step in flight
  logic [CATHODES-1:0] cathodes_d;
  logic [DW-1:0]       digit_d;
  logic                guide1_d, guide2_d, done_d, carry_d, borrow_d, sync_err_d;

  int                  k_cur, k_prev, k_next;
  logic                sense_ok;
  logic [DW-1:0]       sense_digit;
  logic                phase_end;

  function automatic logic [CATHODES-1:0] hot(input int idx);
    return CATHODES'(1) << idx;
  endfunction

  assign phase_end = (cnt_q == CW'(PULSE_CYCLES - 1));

  always_comb begin
    k_cur  = int'(digit_q_int());
    k_prev = (k_cur == 0) ? DIGITS - 1 : k_cur - 1;
    k_next = (k_cur == DIGITS - 1) ? 0 : k_cur + 1;
  end

  function automatic logic [DW-1:0] digit_q_int();
    return digit;
  endfunction

  // A sense pattern is usable only if it equals exactly one main cathode.
  always_comb begin
    sense_ok    = 1'b0;
    sense_digit = '0;
    for (int m = 0; m < DIGITS; m++) begin
      if (sense == hot(3 * m)) begin
        sense_ok    = 1'b1;
        sense_digit = DW'(m);
      end
    end
  end

  // NOTE: every signal this block writes gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    down_d     = down_q;
    cathodes_d = cathodes;
    digit_d    = digit;
    guide1_d   = 1'b0;
    guide2_d   = 1'b0;
    done_d     = 1'b0;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    sync_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (int'(load_digit) < DIGITS) begin
            state_d    = FIN;
            digit_d    = load_digit;
            cathodes_d = hot(3 * int'(load_digit));
            done_d     = 1'b1;
          end else begin
            sync_err_d = 1'b1;
          end
        end else if (sense_en) begin
          if (sense_ok) begin
            state_d    = FIN;
            digit_d    = sense_digit;
            cathodes_d = sense;
            done_d     = 1'b1;
          end else begin
            sync_err_d = 1'b1;
          end
        end else if (inc ^ dec) begin
          // Simultaneous inc and dec cancel and fall through as a no-op.
          state_d = PH1;
          cnt_d   = '0;
          down_d  = dec;
          if (dec) begin
            guide2_d   = 1'b1;
            cathodes_d = hot(3 * k_prev + 2);
          end else begin
            guide1_d   = 1'b1;
            cathodes_d = hot(3 * k_cur + 1);
          end
        end
      end

      PH1: begin
        if (phase_end) begin
          state_d = PH2;
          cnt_d   = '0;
          if (down_q) begin
            guide1_d   = 1'b1;
            cathodes_d = hot(3 * k_prev + 1);
          end else begin
            guide2_d   = 1'b1;
            cathodes_d = hot(3 * k_cur + 2);
          end
        end else begin
          cnt_d    = cnt_q + CW'(1);
          guide1_d = guide1;
          guide2_d = guide2;
        end
      end

      PH2: begin
        if (phase_end) begin
          // digit still holds the pre-step index K until this transition.
          state_d = FIN;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (down_q) begin
            digit_d    = DW'(k_prev);
            cathodes_d = hot(3 * k_prev);
            borrow_d   = (k_cur == 0);
          end else begin
            digit_d    = DW'(k_next);
            cathodes_d = hot(3 * k_next);
            carry_d    = (k_cur == DIGITS - 1);
          end
        end else begin
          cnt_d    = cnt_q + CW'(1);
          guide1_d = guide1;
          guide2_d = guide2;
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      down_q   <= 1'b0;
      cathodes <= CATHODES'(1);
      digit    <= '0;
      guide1   <= 1'b0;
      guide2   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      down_q   <= down_d;
      cathodes <= cathodes_d;
      digit    <= digit_d;
      guide1   <= guide1_d;
      guide2   <= guide2_d;
      busy     <= (state_d != IDLE);
      done     <= done_d;
      carry    <= carry_d;
      borrow   <= borrow_d;
      sync_err <= sync_err_d;
    end
  end

endmodule
